led_pwm_out: RTL and testbench
==============================

// Module: led_pwm_out
// PURPOSE
//  Consumer end of the shared PWM ramp bus. Compares the free-running ramp
//  against a per-channel duty value and drives registered LED PWM outputs.
//  Duty updates enter through a valid/ready write port into per-channel shadow
//  registers. They take effect only at a ramp period boundary, so every LED
//  pulse is glitch-free.
// PARAMETERS
//  CHANNELS  3  number of LED PWM outputs (1..8)
//  WIDTH     8  ramp/duty width in bits; must match the ramp generator width
// PORTS
//  clk            in   1                 system clock
//  rst_n          in   1                 asynchronous active-low reset
//  ramp           in   WIDTH             ramp value, +1 per clk, wraps max->0
//  enable         in   1                 run request; low forces all pwm low
//  wr_valid       in   1                 duty write request
//  wr_ready       out  1                 duty write can be accepted
//  wr_chan        in   3                 target channel index
//  wr_duty        in   WIDTH             new duty (0 = off, N = on for N ramp steps)
//  pwm            out  CHANNELS          registered PWM outputs
//  period_start   out  1                 1-clk pulse, first cycle of each period
//  err            out  1                 sticky: write to wr_chan >= CHANNELS
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Outputs: pwm=0, period_start=0, err=0, wr_ready=1.
//   - Internal: all active/shadow duties = 0, pending flags clear, ramp_q = 0,
//     FSM = OFF. Reset mid-period discards pending writes.
//  Wrap detect
//   - wrap = (ramp < ramp_q); ramp_q is ramp registered every clk.
//   - No false wrap after reset, because ramp_q = 0.
//  Write handshake
//   - wr_ready = ~pending[wr_chan] (combinational on wr_chan); 1 if wr_chan is
//     out of range.
//   - Accept when wr_valid & wr_ready. In range: shadow[ch] <= wr_duty,
//     pending[ch] <= 1. Out of range: write is dropped and err <= 1.
//   - Writes are accepted in every FSM state.
//   - A write accepted in a wrap cycle stays pending until the next wrap. A
//     busy slot cannot also commit, because ready is 0.
//  Commit
//   - In every wrap cycle, each pending channel does active <= shadow and
//     pending <= 0. Commits happen in all FSM states.
//  Compare
//   - duty_eff[i] = (wrap & pending[i]) ? shadow[i] : active[i].
//   - In RUN: pwm[i] <= (ramp < duty_eff[i]). Otherwise pwm[i] <= 0.
//   - 1-clk latency from ramp to pwm.
//   - duty 0: never high. duty 2^WIDTH-1: low for 1 step per period.
//  FSM
//   - OFF  -> SYNC on enable=1.
//   - SYNC -> RUN on wrap & enable, so the first pulse is a whole period.
//   - SYNC -> OFF on enable=0.
//   - RUN  -> OFF on enable=0. pwm is forced 0 in the same clk edge; the
//     partial pulse is truncated.
//  period_start
//   - period_start <= wrap in every state.
// TESTING
//  1. Reset, enable=1, write ch0=64, ramp 0..255 x3 -> pwm[0] starts in the 2nd
//     period; high 64 clks/period, rising 1 clk after ramp=0.
//  2. While in RUN, write ch1=200 at ramp=100 -> the current period is unchanged;
//     from the next ramp=0, pwm[1] is high 200 clks.
//  3. Write ch2 twice before a wrap -> 2nd write sees wr_ready=0 until the
//     ramp=0 cycle; the 1st value commits, the 2nd goes pending.
//  4. Write wr_chan=5 -> accepted, err=1 and stays 1, no pwm change.
//  5. Duty 0 and duty 255 -> pwm stuck low; pwm low exactly 1 clk per period.
//  6. Drop enable mid-pulse -> pwm=0 next clk. Assert rst_n=0 mid-period with a
//     pending write -> all outputs 0 at once; the pending write is lost.

Source files
------------

// File: rtl/led_pwm_out.sv
// LED PWM consumer of the shared ramp bus: per-channel duty compare with
// shadowed duty writes that only take effect at ramp period boundaries.

module led_pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ramp,
    input  logic             wrap,
    input  logic             run,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_duty,
    output logic             pending,
    output logic             pwm
);
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] duty_eff;

    // The committing value must already drive the compare in the wrap cycle.
    assign duty_eff = (wrap && pending) ? shadow : active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            if (wrap && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            // wr_en implies the slot was idle, so it never collides with a commit.
            if (wr_en) begin
                shadow  <= wr_duty;
                pending <= 1'b1;
            end
            pwm <= run && (ramp < duty_eff);
        end
    end
endmodule

module led_pwm_out #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    ramp,
    input  logic                enable,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [2:0]          wr_chan,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start,
    output logic                err
);
    typedef enum logic [1:0] {OFF, SYNC, RUN} state_t;

    state_t              state;
    logic [WIDTH-1:0]    ramp_q;
    logic                wrap;
    logic                run_go;
    logic                chan_ok;
    logic [7:0]          pend8;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_en;

    assign wrap    = ramp < ramp_q;
    assign chan_ok = 32'(wr_chan) < CHANNELS;
    // Unused upper slots read as idle, so out-of-range writes are always ready.
    assign pend8    = 8'(pending);
    assign wr_ready = ~pend8[wr_chan];
    // Entering RUN on a wrap includes that cycle so the first pulse is whole;
    // dropping enable clears pwm on the same edge that leaves RUN.
    assign run_go = enable && ((state == RUN) || ((state == SYNC) && wrap));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        assign wr_en[i] = wr_valid && wr_ready && (wr_chan == 3'(i));

        led_pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ramp    (ramp),
            .wrap    (wrap),
            .run     (run_go),
            .wr_en   (wr_en[i]),
            .wr_duty (wr_duty),
            .pending (pending[i]),
            .pwm     (pwm[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= OFF;
            ramp_q       <= '0;
            period_start <= 1'b0;
            err          <= 1'b0;
        end else begin
            ramp_q       <= ramp;
            period_start <= wrap;
            if (wr_valid && !chan_ok)
                err <= 1'b1;
            case (state)
                OFF:     if (enable) state <= SYNC;
                SYNC:    if (!enable) state <= OFF;
                         else if (wrap) state <= RUN;
                RUN:     if (!enable) state <= OFF;
                default: state <= OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_led_pwm_out.sv
// Directed bench for led_pwm_out: ramp advances by one per clock, duty
// updates are checked against per-period high counts and edge positions.

module tb_led_pwm_out;
    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    ramp;
    logic          enable;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_chan;
    logic [7:0]    wr_duty;
    logic [CH-1:0] pwm;
    logic          period_start;
    logic          err;

    int errors = 0;
    int checks = 0;
    int hi [CH];
    int ps_cnt;
    int n;

    led_pwm_out #(.CHANNELS(CH), .WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ramp         (ramp),
        .enable       (enable),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_chan      (wr_chan),
        .wr_duty      (wr_duty),
        .pwm          (pwm),
        .period_start (period_start),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        ps_cnt = 0;
    endtask

    // One clock: sample registered outputs just after the edge, then advance ramp.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) hi[i] += int'(pwm[i]);
        ps_cnt += int'(period_start);
        ramp = ramp + 8'd1;
    endtask

    task automatic go(input int cnt);
        for (int k = 0; k < cnt; k++) cyc();
    endtask

    task automatic wr(input string tag, input logic [2:0] ch, input logic [7:0] d, input logic exp_rdy);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_duty  = d;
        #1;
        chk(tag, 32'(wr_ready), 32'(exp_rdy));
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ramp = 8'd0; enable = 1'b0;
        wr_valid = 1'b0; wr_chan = 3'd0; wr_duty = 8'd0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        rst_n = 1'b1;
        enable = 1'b1;

        // 1: first period after enable is the SYNC period, pulses begin at the wrap
        wr("t1_ready", 3'd0, 8'd64, 1'b1);
        chk("t1_busy", 32'(wr_ready), 0);
        go(255);
        chk("t1_sync_quiet", 32'(hi[0]), 0);
        clr();
        cyc();
        chk("t1_rise", 32'(pwm[0]), 1);
        chk("t1_ps", 32'(period_start), 1);
        chk("t1_ready_after_commit", 32'(wr_ready), 1);
        go(255);
        chk("t1_hi0", 32'(hi[0]), 64);
        chk("t1_ps_cnt", 32'(ps_cnt), 1);

        // 2: mid-period write to ch1 waits for the next period
        clr();
        go(64);
        chk("t2_hi_at63", 32'(pwm[0]), 1);
        cyc();
        chk("t2_lo_at64", 32'(pwm[0]), 0);
        go(35);
        wr("t2_ready", 3'd1, 8'd200, 1'b1);
        go(155);
        chk("t2_p3_hi0", 32'(hi[0]), 64);
        chk("t2_p3_hi1", 32'(hi[1]), 0);
        chk("t2_p3_ps", 32'(ps_cnt), 1);
        clr();
        go(256);
        chk("t2_p4_hi0", 32'(hi[0]), 64);
        chk("t2_p4_hi1", 32'(hi[1]), 200);
        chk("t2_p4_ps", 32'(ps_cnt), 1);

        // 3: second write to a busy slot stalls until the wrap commits the first
        clr();
        go(10);
        wr("t3_first", 3'd2, 8'd30, 1'b1);
        wr_valid = 1'b1; wr_chan = 3'd2; wr_duty = 8'd90;
        #1;
        chk("t3_stall", 32'(wr_ready), 0);
        n = 0;
        while (!wr_ready && n < 300) begin
            cyc();
            n++;
        end
        chk("t3_stall_len", 32'(n), 246);
        chk("t3_ramp_at_ready", 32'(ramp), 1);
        chk("t3_first_commit", 32'(pwm[2]), 1);
        cyc();
        wr_valid = 1'b0;
        chk("t3_second_pending", 32'(wr_ready), 0);
        go(254);
        chk("t3_hi2_first", 32'(hi[2]), 30);
        clr();
        go(256);
        chk("t3_hi2_second", 32'(hi[2]), 90);

        // 4: out-of-range channel sets sticky err, no pwm effect
        clr();
        chk("t4_err_before", 32'(err), 0);
        wr("t4_ready", 3'd5, 8'd77, 1'b1);
        chk("t4_err", 32'(err), 1);
        go(255);
        chk("t4_hi0", 32'(hi[0]), 64);
        chk("t4_hi1", 32'(hi[1]), 200);
        chk("t4_hi2", 32'(hi[2]), 90);
        chk("t4_err_sticky", 32'(err), 1);

        // 5: duty extremes
        go(5);
        wr("t5_w0", 3'd0, 8'd0, 1'b1);
        wr("t5_w1", 3'd1, 8'd255, 1'b1);
        go(249);
        clr();
        go(256);
        chk("t5_duty0", 32'(hi[0]), 0);
        chk("t5_duty255", 32'(hi[1]), 255);
        chk("t5_hi2", 32'(hi[2]), 90);
        go(255);
        chk("t5_hi_at254", 32'(pwm[1]), 1);
        cyc();
        chk("t5_lo_at255", 32'(pwm[1]), 0);

        // 6: enable drop truncates, async reset clears and drops pending write
        go(11);
        chk("t6_hi_before", 32'(pwm[1]), 1);
        enable = 1'b0;
        cyc();
        chk("t6_disable", 32'(pwm), 0);
        enable = 1'b1;
        go(244);
        cyc();
        chk("t6_rerun", 32'(pwm), 32'b110);
        go(10);
        wr("t6_wr", 3'd2, 8'd10, 1'b1);
        chk("t6_pending", 32'(wr_ready), 0);
        chk("t6_pre_rst", 32'(pwm), 32'b110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pwm", 32'(pwm), 0);
        chk("t6_rst_ps", 32'(period_start), 0);
        chk("t6_rst_err", 32'(err), 0);
        chk("t6_rst_ready", 32'(wr_ready), 1);
        @(posedge clk);
        #1;
        ramp = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr();
        go(512);
        chk("t6_lost_hi0", 32'(hi[0]), 0);
        chk("t6_lost_hi1", 32'(hi[1]), 0);
        chk("t6_lost_hi2", 32'(hi[2]), 0);
        chk("t6_ps_cnt", 32'(ps_cnt), 1);
        chk("t6_ready", 32'(wr_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
